ppu_vram_arb: RTL and testbench

PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

---
 rtl/ppu_vram_arb.sv | 104 ++++++++++
 tb/tb_ppu_vram_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arb.sv
// PPU VRAM arbiter: render fetches win over a one-entry CPU buffer, bounded by a starvation limit.
// Optional stall statistics output enabled by defining PPU_VRAM_ARB_STATS_EN.
module ppu_vram_arb #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rnd_req,
  input  logic [13:0] rnd_addr,
  output logic        rnd_ack,
  output logic        rnd_rvalid,
  output logic [7:0]  rnd_rdata,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ovf,
  output logic [13:0] mem_addr,
  output logic        mem_wr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
`ifdef PPU_VRAM_ARB_STATS_EN
  ,
  output logic [15:0] cpu_stall_cnt
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic        buf_wr;
  logic [13:0] buf_addr;
  logic [7:0]  buf_wdata;
  logic [7:0]  starve_cnt;
  logic [13:0] addr_q;
  logic        rd_pend;
  logic        rd_tag;
  logic [7:0]  cpu_rdata_q;
  logic        rnd_grant;
  logic        cpu_grant;

  // Grants are gated by rst_n so every output reads zero while reset is held.
  assign rnd_grant = rst_n & rnd_req & (starve_cnt < LIMIT);
  assign cpu_grant = rst_n & ~rnd_grant & cpu_busy;

  assign rnd_ack  = rnd_grant;
  assign cpu_ack  = cpu_grant;
  assign cpu_ovf  = cpu_req & cpu_busy;
  assign mem_addr = rnd_grant ? rnd_addr : (cpu_grant ? buf_addr : addr_q);
  assign mem_wr   = cpu_grant & buf_wr;
  assign mem_din  = cpu_grant ? buf_wdata : 8'h00;

  // rd_tag: 0 = render, 1 = CPU; steers the synchronous memory read data.
  assign rnd_rvalid = rd_pend & ~rd_tag;
  assign cpu_rvalid = rd_pend & rd_tag;
  assign rnd_rdata  = rnd_rvalid ? mem_dout : 8'h00;
  assign cpu_rdata  = cpu_rvalid ? mem_dout : cpu_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_busy    <= 1'b0;
      buf_wr      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      starve_cnt  <= '0;
      addr_q      <= '0;
      rd_pend     <= 1'b0;
      rd_tag      <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      addr_q      <= mem_addr;
      rd_pend     <= rnd_grant | (cpu_grant & ~buf_wr);
      rd_tag      <= cpu_grant;
      cpu_rdata_q <= cpu_rdata;

      if (cpu_grant) begin
        cpu_busy <= 1'b0;
      end else if (cpu_req && !cpu_busy) begin
        cpu_busy  <= 1'b1;
        buf_wr    <= cpu_wr;
        buf_addr  <= cpu_addr;
        buf_wdata <= cpu_wdata;
      end

      if (!cpu_busy || cpu_grant)
        starve_cnt <= '0;
      else if (rnd_grant)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

`ifdef PPU_VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cpu_stall_cnt <= '0;
    else if (cpu_busy && !cpu_grant && cpu_stall_cnt != 16'hFFFF)
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed testbench for ppu_vram_arb with a synchronous VRAM model.
// Stall counter checks are included when PPU_VRAM_ARB_STATS_EN is defined.
module tb_ppu_vram_arb;

  logic        clk;
  logic        rst_n;
  logic        rnd_req;
  logic [13:0] rnd_addr;
  logic        rnd_ack;
  logic        rnd_rvalid;
  logic [7:0]  rnd_rdata;
  logic        cpu_req;
  logic        cpu_wr;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        cpu_ovf;
  logic [13:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
`ifdef PPU_VRAM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  logic [7:0] vram [0:16383];
  int checks_total  = 0;
  int checks_passed = 0;

  ppu_vram_arb #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_ack(rnd_ack),
    .rnd_rvalid(rnd_rvalid), .rnd_rdata(rnd_rdata),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_ovf(cpu_ovf),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef PPU_VRAM_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous memory: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) vram[mem_addr] <= mem_din;
    mem_dout <= vram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the falling edge.
  task automatic applyStimulus(input logic r_req, input logic [13:0] r_addr,
                               input logic c_req, input logic c_wr,
                               input logic [13:0] c_addr, input logic [7:0] c_wdata);
    @(posedge clk);
    #1;
    rnd_req   = r_req;
    rnd_addr  = r_addr;
    cpu_req   = c_req;
    cpu_wr    = c_wr;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  grants;
    logic ack_seen;

    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    vram[14'h0010] = 8'h3C;
    vram[14'h2400] = 8'h5A;
    vram[14'h0100] = 8'h77;
    mem_dout = 8'h00;

    rst_n = 1'b0; rnd_req = 1'b0; rnd_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_rnd_ack", rnd_ack, 0);
    checkOutput("rst_cpu_busy", cpu_busy, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 0);
`ifdef PPU_VRAM_ARB_STATS_EN
    checkOutput("rst_stall_cnt", cpu_stall_cnt, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // CPU write with render idle
    applyStimulus(0, 14'h0, 1, 1, 14'h2005, 8'hA5);
    checkOutput("wr_ack_capture", cpu_ack, 0);
    checkOutput("wr_busy_capture", cpu_busy, 0);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("wr_busy", cpu_busy, 1);
    checkOutput("wr_ack", cpu_ack, 1);
    checkOutput("wr_mem_wr", mem_wr, 1);
    checkOutput("wr_mem_addr", mem_addr, 14'h2005);
    checkOutput("wr_mem_din", mem_din, 8'hA5);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("wr_no_rvalid", cpu_rvalid, 0);
    checkOutput("wr_busy_clear", cpu_busy, 0);
    checkOutput("wr_idle_mem_wr", mem_wr, 0);
    checkOutput("wr_idle_addr_hold", mem_addr, 14'h2005);
    checkOutput("wr_vram", vram[14'h2005], 8'hA5);

    // Render read
    applyStimulus(1, 14'h0010, 0, 0, 14'h0, 8'h00);
    checkOutput("rnd_ack", rnd_ack, 1);
    checkOutput("rnd_mem_addr", mem_addr, 14'h0010);
    checkOutput("rnd_mem_wr", mem_wr, 0);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("rnd_rvalid", rnd_rvalid, 1);
    checkOutput("rnd_rdata", rnd_rdata, 8'h3C);
    checkOutput("rnd_no_cpu_rvalid", cpu_rvalid, 0);

    // Starvation: render held high, CPU read buffered
    applyStimulus(1, 14'h0100, 1, 0, 14'h2400, 8'h00);
    checkOutput("starve_rnd_first", rnd_ack, 1);
    grants = 0;
    ack_seen = 1'b0;
    for (int i = 0; i < 20 && !ack_seen; i++) begin
      applyStimulus(1, 14'h0100, 0, 0, 14'h0, 8'h00);
      if (cpu_ack) ack_seen = 1'b1;
      else if (rnd_ack) grants++;
    end
    checkOutput("starve_ack_seen", ack_seen, 1);
    checkOutput("starve_rnd_grants", grants, 8);
    checkOutput("starve_mem_addr", mem_addr, 14'h2400);
    checkOutput("starve_mem_wr", mem_wr, 0);
    checkOutput("starve_rnd_blocked", rnd_ack, 0);
    applyStimulus(1, 14'h0100, 0, 0, 14'h0, 8'h00);
    checkOutput("starve_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("starve_cpu_rdata", cpu_rdata, 8'h5A);
    checkOutput("starve_rnd_resume", rnd_ack, 1);
    checkOutput("starve_busy_clear", cpu_busy, 0);
`ifdef PPU_VRAM_ARB_STATS_EN
    checkOutput("starve_stall_cnt", cpu_stall_cnt, 8);
`endif
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("starve_rnd_rdata", rnd_rdata, 8'h77);
    checkOutput("starve_cpu_rvalid_off", cpu_rvalid, 0);
    checkOutput("starve_cpu_rdata_hold", cpu_rdata, 8'h5A);

    // Back-to-back CPU pulses: second is dropped
    applyStimulus(0, 14'h0, 1, 1, 14'h0005, 8'h11);
    checkOutput("ovf_first", cpu_ovf, 0);
    applyStimulus(0, 14'h0, 1, 1, 14'h0006, 8'h22);
    checkOutput("ovf_pulse", cpu_ovf, 1);
    checkOutput("ovf_ack", cpu_ack, 1);
    checkOutput("ovf_mem_addr", mem_addr, 14'h0005);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("ovf_clear", cpu_ovf, 0);
    checkOutput("ovf_no_second_ack", cpu_ack, 0);
    checkOutput("ovf_busy", cpu_busy, 0);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("ovf_no_late_ack", cpu_ack, 0);
    checkOutput("ovf_vram5", vram[14'h0005], 8'h11);
    checkOutput("ovf_vram6", vram[14'h0006], 8'h00);

    // Reset right after a CPU read grant
    applyStimulus(0, 14'h0, 1, 0, 14'h0010, 8'h00);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("rst_mid_ack", cpu_ack, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_mid_busy", cpu_busy, 0);
    checkOutput("rst_mid_mem_addr", mem_addr, 0);
    checkOutput("rst_mid_mem_wr", mem_wr, 0);
    checkOutput("rst_mid_cpu_rdata", cpu_rdata, 0);
    checkOutput("rst_mid_rnd_rdata", rnd_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rnd_req = 1'b1;
    rnd_addr = 14'h0010;
    @(negedge clk);
    checkOutput("post_rst_no_rvalid", cpu_rvalid, 0);
    checkOutput("post_rst_rnd_ack", rnd_ack, 1);
    applyStimulus(0, 14'h0, 0, 0, 14'h0, 8'h00);
    checkOutput("post_rst_rnd_rdata", rnd_rdata, 8'h3C);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
